// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of INPUT_NUMBER AXI-Stream sources into one
// output channel; a grant is held from routing header to TLAST, output is skid-buffered.
module axis_packet_arbiter #(
    parameter int DATA_WIDTH         = 32,
    parameter int ID_WIDTH           = 4,
    parameter int DEST_WIDTH         = 4,
    parameter int USER_WIDTH         = 4,
    parameter int INPUT_NUMBER       = 5,
    parameter int INPUT_NUMBER_WIDTH = (INPUT_NUMBER > 1) ? $clog2(INPUT_NUMBER) : 1,
    parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [INPUT_NUMBER-1:0]                      in_tvalid_i,
    output logic [INPUT_NUMBER-1:0]                      in_tready_o,
    input  logic [INPUT_NUMBER-1:0][DATA_WIDTH-1:0]      in_tdata_i,
    input  logic [INPUT_NUMBER-1:0][DATA_WIDTH/8-1:0]    in_tstrb_i,
    input  logic [INPUT_NUMBER-1:0][DATA_WIDTH/8-1:0]    in_tkeep_i,
    input  logic [INPUT_NUMBER-1:0]                      in_tlast_i,
    input  logic [INPUT_NUMBER-1:0][ID_WIDTH-1:0]        in_tid_i,
    input  logic [INPUT_NUMBER-1:0][DEST_WIDTH-1:0]      in_tdest_i,
    input  logic [INPUT_NUMBER-1:0][USER_WIDTH-1:0]      in_tuser_i,
    output logic                                         out_tvalid_o,
    input  logic                                         out_tready_i,
    output logic [DATA_WIDTH-1:0]                        out_tdata_o,
    output logic [DATA_WIDTH/8-1:0]                      out_tstrb_o,
    output logic [DATA_WIDTH/8-1:0]                      out_tkeep_o,
    output logic                                         out_tlast_o,
    output logic [ID_WIDTH-1:0]                          out_tid_o,
    output logic [DEST_WIDTH-1:0]                        out_tdest_o,
    output logic [USER_WIDTH-1:0]                        out_tuser_o,
    output logic [INPUT_NUMBER_WIDTH-1:0]                current_grant_o,
    output logic                                         grant_active_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [INPUT_NUMBER_WIDTH-1:0] LAST_IDX = INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic [STRB_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_e                        state_q, state_d;
    logic [INPUT_NUMBER_WIDTH-1:0] grant_q, grant_d;
    logic [INPUT_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [INPUT_NUMBER-1:0]       req;
    logic [INPUT_NUMBER_WIDTH-1:0] winner;
    logic                          found;
    beat_t                         sel_beat;
    logic                          can_accept;
    logic                          push;
    logic                          pop;

    beat_t                         mem_q [2];
    logic                          wr_ptr_q;
    logic                          rd_ptr_q;
    logic [1:0]                    count_q;
    beat_t                         head;

    always_comb begin
        for (int i = 0; i < INPUT_NUMBER; i++) begin
            req[i] = in_tvalid_i[i] && (in_tid_i[i] == ROUTING_HEADER);
        end
    end

    // Scan starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int unsigned idx;
        // NOTE: every variable written here gets a default first, otherwise an incomplete path infers a latch.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < INPUT_NUMBER; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= INPUT_NUMBER) idx = idx - INPUT_NUMBER;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = INPUT_NUMBER_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        sel_beat.data = in_tdata_i[grant_q];
        sel_beat.strb = in_tstrb_i[grant_q];
        sel_beat.keep = in_tkeep_i[grant_q];
        sel_beat.last = in_tlast_i[grant_q];
        sel_beat.id   = in_tid_i[grant_q];
        sel_beat.dest = in_tdest_i[grant_q];
        sel_beat.user = in_tuser_i[grant_q];
    end

    assign can_accept = (state_q == LOCKED) && (count_q != 2'd2);
    assign push       = can_accept && in_tvalid_i[grant_q];
    assign pop        = (count_q != 2'd0) && out_tready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    grant_d = winner;
                end
            end
            LOCKED: begin
                if (push && sel_beat.last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_tready_o = '0;
        if (can_accept) in_tready_o[grant_q] = 1'b1;
        grant_active_o  = (state_q == LOCKED);
        current_grant_o = grant_q;
    end

    // Two-entry skid FIFO: the input side only looks at the local count, never at out_tready_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset because they drive the output payload directly.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= sel_beat;
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_tvalid_o = (count_q != 2'd0);
    assign out_tdata_o  = head.data;
    assign out_tstrb_o  = head.strb;
    assign out_tkeep_o  = head.keep;
    assign out_tlast_o  = head.last;
    assign out_tid_o    = head.id;
    assign out_tdest_o  = head.dest;
    assign out_tuser_o  = head.user;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-input beat tables feed the DUT, the
// output is captured beat by beat and compared with hand-written expected sequences.
module tb_axis_packet_arbiter;

    localparam int NI    = 5;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int SW    = DW / 8;
    localparam int GW    = 3;
    localparam int DEPTH = 16;
    localparam int RXD   = 64;
    localparam logic [IW-1:0] HDR = 4'hF;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NI-1:0]          in_tvalid_i;
    logic [NI-1:0]          in_tready_o;
    logic [NI-1:0][DW-1:0]  in_tdata_i;
    logic [NI-1:0][SW-1:0]  in_tstrb_i;
    logic [NI-1:0][SW-1:0]  in_tkeep_i;
    logic [NI-1:0]          in_tlast_i;
    logic [NI-1:0][IW-1:0]  in_tid_i;
    logic [NI-1:0][3:0]     in_tdest_i;
    logic [NI-1:0][3:0]     in_tuser_i;
    logic                   out_tvalid_o;
    logic                   out_tready_i;
    logic [DW-1:0]          out_tdata_o;
    logic [SW-1:0]          out_tstrb_o;
    logic [SW-1:0]          out_tkeep_o;
    logic                   out_tlast_o;
    logic [IW-1:0]          out_tid_o;
    logic [3:0]             out_tdest_o;
    logic [3:0]             out_tuser_o;
    logic [GW-1:0]          current_grant_o;
    logic                   grant_active_o;

    axis_packet_arbiter #(
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (IW),
        .DEST_WIDTH     (4),
        .USER_WIDTH     (4),
        .INPUT_NUMBER   (NI),
        .ROUTING_HEADER (HDR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_tvalid_i     (in_tvalid_i),
        .in_tready_o     (in_tready_o),
        .in_tdata_i      (in_tdata_i),
        .in_tstrb_i      (in_tstrb_i),
        .in_tkeep_i      (in_tkeep_i),
        .in_tlast_i      (in_tlast_i),
        .in_tid_i        (in_tid_i),
        .in_tdest_i      (in_tdest_i),
        .in_tuser_i      (in_tuser_i),
        .out_tvalid_o    (out_tvalid_o),
        .out_tready_i    (out_tready_i),
        .out_tdata_o     (out_tdata_o),
        .out_tstrb_o     (out_tstrb_o),
        .out_tkeep_o     (out_tkeep_o),
        .out_tlast_o     (out_tlast_o),
        .out_tid_o       (out_tid_o),
        .out_tdest_o     (out_tdest_o),
        .out_tuser_o     (out_tuser_o),
        .current_grant_o (current_grant_o),
        .grant_active_o  (grant_active_o)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [DW-1:0] src_data [NI][DEPTH];
    logic          src_last [NI][DEPTH];
    logic [IW-1:0] src_tid  [NI][DEPTH];
    int            src_len  [NI];
    int            src_pos  [NI];
    int            in_hs_cnt[NI];

    logic [DW-1:0] rx_data [RXD];
    logic          rx_last [RXD];
    logic [IW-1:0] rx_tid  [RXD];
    int            rx_cnt;
    logic [DW-1:0] exp_data[RXD];
    logic          exp_last[RXD];
    int            exp_cnt;

    int            mdl_cnt;
    int            max_cnt;
    int            stall_seen;
    int            cyc = 0;
    int            first_valid_cyc;
    int            header_cyc;
    logic          release_pending;
    logic          hold_pending;
    logic [DW-1:0] held_data;
    logic          rdy_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NI; i++) begin
            in_tstrb_i[i] = '1;
            in_tkeep_i[i] = '1;
            in_tdest_i[i] = 4'(i);
            in_tuser_i[i] = 4'(NI - i);
            if (src_pos[i] < src_len[i]) begin
                in_tvalid_i[i] = 1'b1;
                in_tdata_i[i]  = src_data[i][src_pos[i]];
                in_tlast_i[i]  = src_last[i][src_pos[i]];
                in_tid_i[i]    = src_tid[i][src_pos[i]];
            end else begin
                in_tvalid_i[i] = 1'b0;
                in_tdata_i[i]  = '0;
                in_tlast_i[i]  = 1'b0;
                in_tid_i[i]    = '0;
            end
        end
    endtask

    task automatic load_beat(input int src, input logic [DW-1:0] data, input logic [IW-1:0] tid,
                             input logic last);
        src_data[src][src_len[src]] = data;
        src_tid[src][src_len[src]]  = tid;
        src_last[src][src_len[src]] = last;
        src_len[src]++;
        drive_inputs();
    endtask

    task automatic load_pkt(input int src, input int nbeats, input logic [DW-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            load_beat(src, base + DW'(b), (b == 0) ? HDR : 4'h0, b == nbeats - 1);
        end
    endtask

    task automatic expect_pkt(input int nbeats, input logic [DW-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            exp_data[exp_cnt] = base + DW'(b);
            exp_last[exp_cnt] = (b == nbeats - 1);
            exp_cnt++;
        end
    endtask

    task automatic clear_streams();
        for (int i = 0; i < NI; i++) begin
            src_len[i]   = 0;
            src_pos[i]   = 0;
            in_hs_cnt[i] = 0;
        end
        rx_cnt          = 0;
        exp_cnt         = 0;
        first_valid_cyc = -1;
        stall_seen      = 0;
        max_cnt         = 0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_streams();
        mdl_cnt         = 0;
        release_pending = 1'b0;
        hold_pending    = 1'b0;
        rdy_next        = 1'b1;
        out_tready_i    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        cyc++;
    endtask

    // Observe everything at the falling edge, then advance stimulus just after the rising edge.
    task automatic run_cycle();
        logic [NI-1:0] hs;
        logic          pop;
        @(negedge clk);
        if (release_pending) begin
            check("release", grant_active_o, 1'b0);
            release_pending = 1'b0;
        end
        if (hold_pending) begin
            check("hold_stable", out_tdata_o, held_data);
            hold_pending = 1'b0;
        end
        check("vld_vs_fill", out_tvalid_o, mdl_cnt != 0);
        if (mdl_cnt == 2) begin
            check("full_stall", |in_tready_o, 1'b0);
            stall_seen++;
        end
        hs = '0;
        for (int i = 0; i < NI; i++) begin
            if (in_tvalid_i[i] && in_tready_o[i]) begin
                hs[i] = 1'b1;
                in_hs_cnt[i]++;
                if (in_tlast_i[i]) release_pending = 1'b1;
            end
        end
        pop = out_tvalid_o && out_tready_i;
        if (out_tvalid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_tvalid_o && !out_tready_i) begin
            hold_pending = 1'b1;
            held_data    = out_tdata_o;
        end
        if (pop && rx_cnt < RXD) begin
            rx_data[rx_cnt] = out_tdata_o;
            rx_last[rx_cnt] = out_tlast_o;
            rx_tid[rx_cnt]  = out_tid_o;
            rx_cnt++;
        end
        mdl_cnt = mdl_cnt + ((|hs) ? 1 : 0) - (pop ? 1 : 0);
        if (mdl_cnt > max_cnt) max_cnt = mdl_cnt;
        @(posedge clk) #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (hs[i]) src_pos[i]++;
        end
        drive_inputs();
        out_tready_i = rdy_next;
    endtask

    task automatic run_until_rx(input int n, input int budget);
        for (int k = 0; k < budget && rx_cnt < n; k++) run_cycle();
    endtask

    task automatic check_rx();
        check("rx_count", rx_cnt, exp_cnt);
        for (int k = 0; k < exp_cnt && k < rx_cnt; k++) begin
            check("rx_data", rx_data[k], exp_data[k]);
            check("rx_last", rx_last[k], exp_last[k]);
        end
    endtask

    initial begin
        rdy_next     = 1'b1;
        out_tready_i = 1'b1;
        mdl_cnt      = 0;
        hold_pending = 1'b0;
        release_pending = 1'b0;
        clear_streams();

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", out_tvalid_o, 1'b0);
        check("rst_active", grant_active_o, 1'b0);
        check("rst_grant", current_grant_o, 0);
        check("rst_tready", in_tready_o, 0);
        check("rst_tdata", out_tdata_o, 0);
        check("rst_tlast", out_tlast_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Single source on in[2]
        clear_streams();
        load_pkt(2, 4, 32'hA0);
        header_cyc = cyc;
        run_until_rx(4, 40);
        expect_pkt(4, 32'hA0);
        check_rx();
        check("latency", first_valid_cyc - header_cyc, 2);
        check("hdr_tid", rx_tid[0], HDR);
        check("grant_2", current_grant_o, 2);
        check("idle_after", grant_active_o, 1'b0);

        // Contention from rr_ptr = 0: order 0, 1, 3
        do_reset();
        load_pkt(0, 2, 32'h00);
        load_pkt(1, 2, 32'h10);
        load_pkt(3, 2, 32'h30);
        run_until_rx(6, 60);
        expect_pkt(2, 32'h00);
        expect_pkt(2, 32'h10);
        expect_pkt(2, 32'h30);
        check_rx();
        check("grant_3_kept", current_grant_o, 3);

        // Fairness wrap from rr_ptr = 4: order 0, 3
        clear_streams();
        load_pkt(3, 2, 32'h230);
        load_pkt(0, 2, 32'h200);
        run_until_rx(4, 40);
        expect_pkt(2, 32'h200);
        expect_pkt(2, 32'h230);
        check_rx();

        // Backpressure during a 6-beat packet
        clear_streams();
        load_pkt(1, 6, 32'hB0);
        for (int k = 0; k < 60 && rx_cnt < 6; k++) begin
            rdy_next = !(k >= 3 && k <= 7);
            run_cycle();
        end
        rdy_next = 1'b1;
        run_cycle();
        expect_pkt(6, 32'hB0);
        check_rx();
        check("stall_seen", stall_seen != 0, 1'b1);
        check("max_fill", max_cnt, 2);

        // Non-header flit while idle is stalled
        clear_streams();
        load_beat(1, 32'hEE, 4'h0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            run_cycle();
            check("nohdr_tready", in_tready_o[1], 1'b0);
            check("nohdr_active", grant_active_o, 1'b0);
            check("nohdr_tvalid", out_tvalid_o, 1'b0);
        end
        check("nohdr_held", in_tvalid_i[1], 1'b1);

        // Reset mid-packet, then a fresh header from in[3]
        clear_streams();
        load_pkt(0, 4, 32'hC0);
        for (int k = 0; k < 40 && in_hs_cnt[0] < 2; k++) run_cycle();
        check("mid_hs", in_hs_cnt[0], 2);
        check("pre_rst_vld", out_tvalid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", out_tvalid_o, 1'b0);
        check("mid_rst_active", grant_active_o, 1'b0);
        check("mid_rst_tready", in_tready_o, 0);
        do_reset();
        load_pkt(3, 2, 32'hD0);
        run_until_rx(2, 40);
        expect_pkt(2, 32'hD0);
        check_rx();
        check("post_rst_grant", current_grant_o, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Output-side counterpart of the router's per-input routing/demux stage: merges up to INPUT_NUMBER AXI-Stream sources that target one router output channel into a single output stream.
- Arbitration is round-robin and packet-granular (wormhole). A grant is taken on a routing-header flit (TID == ROUTING_HEADER) and held until the TLAST beat of that packet is accepted.
- A registered 2-entry skid buffer drives the output, which cuts the combinational TREADY/TVALID path between input and output links.
- The current grant is exported so the upstream routing stage can steer dual-channel selection.

Parameters:
- DATA_WIDTH, 32, TDATA width.
- ID_WIDTH, 4, TID width. Only when TID_PRESENT is defined; TID is mandatory for this block.
- DEST_WIDTH, 4, TDEST width. Only when TDEST_PRESENT is defined.
- USER_WIDTH, 4, TUSER width. Only when TUSER_PRESENT is defined.
- INPUT_NUMBER, 5, number of contending input streams.
- INPUT_NUMBER_WIDTH, $clog2(INPUT_NUMBER), width of the grant index.

Ports:
- clk  input  1  clock. Single clock domain; everything is registered on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in  axis_if.s  array [INPUT_NUMBER]  contending input streams, all fields as enabled by defines.
- out  axis_if.m  1  merged output stream.
- current_grant  output  INPUT_NUMBER_WIDTH  index of the input currently or most recently granted.
- grant_active  output  1  high while state is LOCKED.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, current_grant = 0, grant_active = 0.
  - Skid count = 0, so out.TVALID = 0.
  - All out payload fields = 0.
  - All in[i].TREADY = 0.
- Request vector: req[i] = in[i].TVALID && (in[i].TID == ROUTING_HEADER).
- IDLE state:
  - All in[i].TREADY = 0.
  - If req is nonzero, select the first set bit scanning from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., INPUT_NUMBER-1, 0, ..., rr_ptr-1).
  - At the clock edge: register the winner into current_grant, set grant_active = 1, move to LOCKED.
  - No beat is consumed in the arbitration cycle.
  - A non-header flit presented in IDLE is stalled (TREADY = 0), never dropped.
- LOCKED state:
  - in[current_grant].TREADY = (skid count < 2). All other in[i].TREADY = 0.
  - On the handshake, the beat (TDATA/TSTRB/TKEEP/TLAST/TID/TDEST/TUSER as present) is written to the skid buffer unmodified.
  - TID is not inspected while locked.
  - When the accepted beat has TLAST = 1: move to IDLE, set rr_ptr = (current_grant + 1) mod INPUT_NUMBER, set grant_active = 0. current_grant keeps its value.
- Skid buffer:
  - 2-entry FIFO, registered outputs. out.TVALID = (count != 0); out payload = head entry.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when out.TVALID && out.TREADY.
  - out payload is stable while TVALID && !TREADY.
- Latency and throughput:
  - Header visible at cycle 0 → grant at edge 1 → header accepted at edge 2 (buffer not full) → out.TVALID high after edge 2.
  - Subsequent beats: 1 cycle input to output, 1 beat per cycle sustained when out.TREADY = 1.
  - A new arbitration can start the cycle after TLAST is accepted, even while the buffer still drains. Buffer order guarantees no interleaving.
- Single-beat packet (header with TLAST = 1): lock, accept one beat, release. Minimum 2 cycles per packet per grant.
- Full buffer: granted TREADY = 0 until a pop. A simultaneous pop and push with count = 2 is not allowed, because TREADY was already low.
- Granted input dropping TVALID mid-packet: stay LOCKED indefinitely; no timeout.
- Reset asserted mid-packet: all state and buffered beats are discarded immediately (asynchronously). After release, arbitration restarts from rr_ptr = 0.
- INPUT_NUMBER = 1 must work: rr_ptr stays 0.

Test Plan:
- Single source: in[2] sends header with TID = ROUTING_HEADER followed by 3 beats 0xA0..0xA3, TLAST on the last, out.TREADY = 1 → out carries 0xA0..0xA3 in order, first out.TVALID 2 cycles after the header is presented, current_grant = 2, grant_active falls after the 0xA3 handshake.
- Contention: in[0], in[1] and in[3] all present 2-beat packets at cycle 0, rr_ptr = 0 → output packet order is 0, 1, 3; no interleaving; rr_ptr = 4 after the third packet.
- Fairness wrap: rr_ptr = 4 with in[4] idle and in[0] and in[3] requesting → grant goes to 0, then 3.
- Backpressure: out.TREADY held low for 5 cycles during a 6-beat packet → at most 2 beats buffered, granted TREADY low while count = 2, no beat lost or duplicated once out.TREADY returns high.
- Non-header flit in IDLE: in[1] presents TID ≠ ROUTING_HEADER → in[1].TREADY stays 0, no grant, out.TVALID stays 0.
- Reset mid-packet: assert rst_n = 0 after 2 of 4 beats → out.TVALID = 0 and grant_active = 0 immediately. After release, a fresh header from in[3] is granted normally with current_grant = 3.
